// File: rtl/row_regs_filler.sv
// row_regs_filler
//
// Consumer end of the conv pixel-command stream. Each accepted command is
// one row segment. It causes one unaligned 32-pixel read from the input row
// buffer. The segment is then written into a local pixel register array in
// this order: west pad zeros, saved overlap (slab) pixels, buffer pixels,
// then east pad zeros. A later write wins where two of them land on the same
// position.
//
// After the last segment of a tile row, the array is presented to the PE
// side. It is held until that side takes it. The tail of the finished row is
// kept in slab_save, so the next tile can replay it as its overlap.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_row_start_idx     first row pixel index of the segment
//   cmd_west_pad          leading zero count
//   cmd_slab_num          saved overlap pixel count (clamped to SLAB_MAX)
//   cmd_east_pad          trailing zero count
//   cmd_reg_start_idx     first register position for buffer pixels
//   cmd_reg_end_idx       last register position written (incl. east pad)
//   cmd_last              segment closes the tile row
//   buf_rd_en/addr        one-cycle read strobe and pixel index
//   buf_rd_data           32 pixels, valid the cycle after the strobe
//   regs_flat             register array, position n at [n*PIXEL_W +: PIXEL_W]
//   regs_valid            array complete, waiting for regs_taken
//   regs_taken            PE side takes the array (clears it)
//   err_overflow          sticky: some write aimed at a position >= REGS_NUM
module row_regs_filler #(
  parameter int PIXELS_IN_ROW = 32,
  parameter int PIXEL_W       = 8,
  parameter int REGS_NUM      = 64,
  parameter int SLAB_MAX      = 15
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [15:0]                       cmd_row_start_idx,
  input  logic [3:0]                        cmd_west_pad,
  input  logic [3:0]                        cmd_slab_num,
  input  logic [3:0]                        cmd_east_pad,
  input  logic [15:0]                       cmd_reg_start_idx,
  input  logic [15:0]                       cmd_reg_end_idx,
  input  logic                              cmd_last,
  output logic                              buf_rd_en,
  output logic [15:0]                       buf_rd_addr,
  input  logic [PIXELS_IN_ROW*PIXEL_W-1:0]  buf_rd_data,
  output logic [REGS_NUM*PIXEL_W-1:0]       regs_flat,
  output logic                              regs_valid,
  input  logic                              regs_taken,
  output logic                              err_overflow
);

  localparam int              LP_OFF_W      = $clog2(PIXELS_IN_ROW);
  localparam logic [15:0]     LP_REGS_NUM16 = 16'(REGS_NUM);
  localparam logic [15:0]     LP_SLAB_MAX16 = 16'(SLAB_MAX);
  localparam logic [16:0]     LP_PIX17      = 17'(PIXELS_IN_ROW);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched command fields; the counts are kept zero-extended to 16 bits
  logic [15:0] r_row_start;
  logic [15:0] r_reg_start;
  logic [15:0] r_reg_end;
  logic [15:0] r_west;
  logic [15:0] r_slab;
  logic [15:0] r_east;
  logic        r_last;

  logic [REGS_NUM*PIXEL_W-1:0] r_regs;
  logic [REGS_NUM*PIXEL_W-1:0] w_regs_next;
  logic [SLAB_MAX*PIXEL_W-1:0] r_slab_save;
  logic [SLAB_MAX*PIXEL_W-1:0] w_slab_next;
  logic                        r_err_overflow;
  logic                        w_overflow;

  logic [15:0] w_cmd_slab;
  logic [15:0] w_data_end;
  logic [16:0] w_span;
  logic [16:0] w_n;
  logic [15:0] w_pos;
  logic [15:0] w_off;
  logic [15:0] w_tgt;
  logic [15:0] w_src;
  int          w_k;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and the state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    buf_rd_en    = 1'b0;
    buf_rd_addr  = '0;
    regs_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_next = READ;
        end
      end
      READ: begin
        buf_rd_en    = 1'b1;
        buf_rd_addr  = r_row_start;
        w_state_next = WRITE;
      end
      WRITE: begin
        w_state_next = r_last ? DONE : IDLE;
      end
      DONE: begin
        regs_valid = 1'b1;
        if (regs_taken) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Command capture on handshake. The fields only have to be stable in that
  // one cycle, so everything later uses these copies.
  assign w_cmd_slab = {12'd0, cmd_slab_num};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_start <= '0;
      r_reg_start <= '0;
      r_reg_end   <= '0;
      r_west      <= '0;
      r_slab      <= '0;
      r_east      <= '0;
      r_last      <= 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      r_row_start <= cmd_row_start_idx;
      r_reg_start <= cmd_reg_start_idx;
      r_reg_end   <= cmd_reg_end_idx;
      r_west      <= {12'd0, cmd_west_pad};
      r_slab      <= (w_cmd_slab > LP_SLAB_MAX16) ? LP_SLAB_MAX16 : w_cmd_slab;
      r_east      <= {12'd0, cmd_east_pad};
      r_last      <= cmd_last;
    end
  end

  // Buffer pixel count. The span is computed in 17 bits so that a full
  // 16-bit range cannot wrap to a small count.
  assign w_data_end = r_reg_end - r_east;
  assign w_span     = {1'b0, w_data_end} - {1'b0, r_reg_start} + 17'd1;
  assign w_n        = (w_data_end < r_reg_start) ? 17'd0 :
                      (w_span > LP_PIX17) ? LP_PIX17 : w_span;

  // Next array contents. The steps are evaluated per position in priority
  // order, so a later step overrides an earlier one. Position 0 is skipped,
  // which keeps it at zero. The slab tail is captured from the post-write
  // values, so that the segment just written is included.
  always_comb begin
    w_regs_next = r_regs;
    w_slab_next = r_slab_save;
    w_overflow  = 1'b0;
    w_pos       = '0;
    w_off       = '0;
    w_tgt       = '0;
    w_src       = '0;
    w_k         = 0;
    if (r_state == WRITE) begin
      for (int p = 1; p < REGS_NUM; p++) begin
        w_pos = 16'(p);
        if (w_pos <= r_west) begin
          w_regs_next[p*PIXEL_W +: PIXEL_W] = '0;
        end
        if ((w_pos > r_west) && (w_pos <= r_west + r_slab)) begin
          w_k = SLAB_MAX - int'(r_slab) + int'(w_pos - r_west) - 1;
          w_regs_next[p*PIXEL_W +: PIXEL_W] = r_slab_save[w_k*PIXEL_W +: PIXEL_W];
        end
        w_off = w_pos - r_reg_start;
        if ({1'b0, w_off} < w_n) begin
          w_regs_next[p*PIXEL_W +: PIXEL_W] =
            buf_rd_data[w_off[LP_OFF_W-1:0]*PIXEL_W +: PIXEL_W];
        end
        if ((w_pos > w_data_end) && (w_pos <= r_reg_end)) begin
          w_regs_next[p*PIXEL_W +: PIXEL_W] = '0;
        end
      end
      // Pad and slab targets stay below 31 and cannot overflow. Only the
      // data run and the east pad can reach past the array.
      for (int i = 0; i < PIXELS_IN_ROW; i++) begin
        w_tgt = r_reg_start + 16'(i);
        if ((17'(i) < w_n) && (w_tgt >= LP_REGS_NUM16)) begin
          w_overflow = 1'b1;
        end
      end
      if ((w_data_end < r_reg_end) && (r_reg_end >= LP_REGS_NUM16)) begin
        w_overflow = 1'b1;
      end
      // A source below position 1 wraps to a huge value and fails the range
      // test. That gives the required zero.
      if (r_last) begin
        for (int j = 0; j < SLAB_MAX; j++) begin
          w_src = w_data_end - (LP_SLAB_MAX16 - 16'd1) + 16'(j);
          if ((w_src != 16'd0) && (w_src < LP_REGS_NUM16)) begin
            w_slab_next[j*PIXEL_W +: PIXEL_W] = w_regs_next[int'(w_src)*PIXEL_W +: PIXEL_W];
          end else begin
            w_slab_next[j*PIXEL_W +: PIXEL_W] = '0;
          end
        end
      end
    end else if ((r_state == DONE) && regs_taken) begin
      w_regs_next = '0;
    end
  end

  // Array, overlap tail and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs         <= '0;
      r_slab_save    <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      r_regs      <= w_regs_next;
      r_slab_save <= w_slab_next;
      if (w_overflow) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

  assign regs_flat    = r_regs;
  assign err_overflow = r_err_overflow;

endmodule
